stream_mux_n: RTL and testbench

- N-channel, W-bit registered stream multiplexer with valid/ready handshake and packet-boundary switching. Parametrised successor of the plain 2:1 select mux.
- Sits between several packet sources and one sink. The selected channel stays locked for a whole packet (until its last beat).
- Select source is either an external select port or a built-in round-robin arbiter, chosen by MODE.

---
 rtl/stream_mux_n_if.sv | 14 +
 rtl/stream_mux_n.sv | 104 ++++++++++
 tb/tb_stream_mux_n.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_mux_n_if.sv
// Valid/ready stream bundle carrying LANES parallel channels of W-bit data.
// The mux takes an N-lane bundle on its input side and a 1-lane bundle on its output side.
interface stream_mux_n_if #(
    parameter int unsigned LANES = 1,
    parameter int unsigned W     = 8
);
    logic [LANES*W-1:0] data;
    logic [LANES-1:0]   valid;
    logic [LANES-1:0]   last;
    logic [LANES-1:0]   ready;

    modport master (output data, valid, last, input  ready);
    modport slave  (input  data, valid, last, output ready);
endinterface

// File: rtl/stream_mux_n.sv
// N-channel registered stream multiplexer with packet-boundary switching.
// The channel is picked by an external select (MODE 0) or round-robin (MODE 1) and then held for the whole packet.
module stream_mux_n #(
    parameter int unsigned N     = 4,
    parameter int unsigned W     = 8,
    parameter int unsigned MODE  = 0,
    parameter int unsigned SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SEL_W-1:0] sel,
    stream_mux_n_if.slave    in_s,
    stream_mux_n_if.master   out_s,
    output logic [SEL_W-1:0] cur_sel,
    output logic             busy
);
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t           state;
    logic [W-1:0]     data_q;
    logic             valid_q;
    logic             last_q;
    logic [SEL_W-1:0] rr_ptr;

    logic [SEL_W-1:0] cand;
    logic [SEL_W-1:0] idx;
    logic             cand_ok;
    logic             can_load;
    logic [N-1:0]     ready;
    logic [W-1:0]     cand_data;
    logic             cand_last;
    logic             xfer_in;

    assign can_load = !valid_q || out_s.ready[0];

    always_comb begin
        cand    = '0;
        cand_ok = 1'b0;
        idx     = '0;
        if (state == LOCKED) begin
            cand    = cur_sel;
            cand_ok = 1'b1;
        end else if (MODE == 0) begin
            if (32'(sel) < N) begin
                cand    = sel;
                cand_ok = 1'b1;
            end
        end else begin
            // First valid channel after rr_ptr wins, so the last served channel ranks lowest.
            for (int unsigned k = 1; k <= N; k++) begin
                idx = SEL_W'((32'(rr_ptr) + k) % N);
                if (!cand_ok && in_s.valid[idx]) begin
                    cand    = idx;
                    cand_ok = 1'b1;
                end
            end
        end
    end

    always_comb begin
        ready     = '0;
        cand_data = '0;
        cand_last = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            ready[i] = rst_n && cand_ok && can_load && (cand == SEL_W'(i));
            if (cand == SEL_W'(i)) begin
                cand_data = in_s.data[i*W +: W];
                cand_last = in_s.last[i];
            end
        end
    end

    assign xfer_in    = |(in_s.valid & ready);
    assign in_s.ready = ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            cur_sel <= '0;
            rr_ptr  <= SEL_W'(N - 1);
        end else if (xfer_in) begin
            data_q  <= cand_data;
            last_q  <= cand_last;
            valid_q <= 1'b1;
            cur_sel <= cand;
            if (cand_last) begin
                state  <= IDLE;
                rr_ptr <= cand;
            end else begin
                state  <= LOCKED;
            end
        end else if (valid_q && out_s.ready[0]) begin
            valid_q <= 1'b0;
        end
    end

    assign busy        = (state == LOCKED);
    assign out_s.data  = data_q;
    assign out_s.valid = valid_q;
    assign out_s.last  = last_q;
endmodule

// File: tb/tb_stream_mux_n.sv
// Scoreboard bench for stream_mux_n: a shared 4-channel source drives either the select-mode or the round-robin
// instance, plus a 3-channel instance for the out-of-range select case.
module tb_stream_mux_n;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    stream_mux_n_if #(.LANES(4), .W(8)) i0 ();
    stream_mux_n_if #(.LANES(1), .W(8)) o0 ();
    stream_mux_n_if #(.LANES(4), .W(8)) i1 ();
    stream_mux_n_if #(.LANES(1), .W(8)) o1 ();
    stream_mux_n_if #(.LANES(3), .W(8)) i2 ();
    stream_mux_n_if #(.LANES(1), .W(8)) o2 ();

    logic [1:0] sel = 2'd0;
    logic [1:0] sel2 = 2'd0;
    logic [1:0] cs0, cs1, cs2;
    logic       busy0, busy1, busy2;
    logic       use_rr = 1'b0;
    logic       bp_en = 1'b0;
    logic       out_ready = 1'b1;

    stream_mux_n #(.N(4), .W(8), .MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .sel(sel), .in_s(i0), .out_s(o0), .cur_sel(cs0), .busy(busy0));
    stream_mux_n #(.N(4), .W(8), .MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .sel(sel), .in_s(i1), .out_s(o1), .cur_sel(cs1), .busy(busy1));
    stream_mux_n #(.N(3), .W(8), .MODE(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .sel(sel2), .in_s(i2), .out_s(o2), .cur_sel(cs2), .busy(busy2));

    // Shared source: per-channel beat queues {last, data}
    logic [8:0]  srcq [4][$];
    logic [8:0]  exp_q [$];
    logic [3:0]  src_valid = '0;
    logic [3:0]  src_last = '0;
    logic [31:0] src_data = '0;
    logic [3:0]  src_ready;
    logic [3:0]  fire = '0;

    assign i0.data  = src_data;
    assign i0.last  = src_last;
    assign i0.valid = use_rr ? 4'b0000 : src_valid;
    assign i1.data  = src_data;
    assign i1.last  = src_last;
    assign i1.valid = use_rr ? src_valid : 4'b0000;
    assign src_ready = use_rr ? i1.ready : i0.ready;
    assign o0.ready = out_ready;
    assign o1.ready = out_ready;

    assign i2.data  = 24'h222120;
    assign i2.valid = 3'b111;
    assign i2.last  = 3'b111;
    assign o2.ready = 1'b1;

    logic       act_valid, act_last, act_busy;
    logic [7:0] act_data;
    logic [3:0] act_ready;
    assign act_valid = use_rr ? o1.valid[0] : o0.valid[0];
    assign act_last  = use_rr ? o1.last[0]  : o0.last[0];
    assign act_data  = use_rr ? o1.data     : o0.data;
    assign act_busy  = use_rr ? busy1 : busy0;
    assign act_ready = src_ready;

    always @(negedge clk) fire = src_valid & src_ready;

    always @(posedge clk) begin
        #1;
        for (int c = 0; c < 4; c++) begin
            if (fire[c] && srcq[c].size() > 0) void'(srcq[c].pop_front());
            if (srcq[c].size() > 0) begin
                src_valid[c]       = 1'b1;
                src_data[c*8 +: 8] = srcq[c][0][7:0];
                src_last[c]        = srcq[c][0][8];
            end else begin
                src_valid[c]       = 1'b0;
                src_data[c*8 +: 8] = 8'h00;
                src_last[c]        = 1'b0;
            end
        end
    end

    logic [3:0] bp_pat = 4'b1001;
    int         bp_i = 0;
    always @(posedge clk) begin
        #1;
        if (bp_en) begin
            out_ready = bp_pat[bp_i];
            bp_i = (bp_i + 1) % 4;
        end else begin
            out_ready = 1'b1;
        end
    end

    logic       bp_chk = 1'b0;
    logic       busy_chk = 1'b0;
    logic       stall_prev = 1'b0;
    logic [7:0] stall_data = '0;
    always @(negedge clk) begin
        if (rst_n && act_valid) begin
            if (bp_chk && stall_prev) chk("stall_hold", act_data, stall_data);
            if (busy_chk) chk("busy_mid", act_busy, !act_last);
            if (bp_chk && !out_ready) chk("stall_rdy", act_ready, 0);
            stall_prev = !out_ready;
            stall_data = act_data;
            if (out_ready) begin
                chk("sb_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("sb_data", {act_last, act_data}, exp_q.pop_front());
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic wait_drain(input string tag, input int exp_n);
        int n = 0;
        bit started = 1'b0;
        int guard = 0;
        while (guard < 500) begin
            @(negedge clk); #2;
            guard++;
            if (act_valid) started = 1'b1;
            if (started) n++;
            if (started && exp_q.size() == 0) break;
        end
        chk({tag, "_done"}, exp_q.size(), 0);
        if (exp_n > 0) chk({tag, "_cyc"}, n, exp_n);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

    logic [3:0] t1_rdy [4];
    logic       t1_busy [4];
    logic       t1_ov [4];

    initial begin
        t1_rdy  = '{4'b0100, 4'b0100, 4'b0100, 4'b0010};
        t1_busy = '{1'b0, 1'b1, 1'b1, 1'b0};
        t1_ov   = '{1'b0, 1'b1, 1'b1, 1'b1};

        repeat (3) @(negedge clk);
        chk("rst_ov0", o0.valid, 0);
        chk("rst_ov1", o1.valid, 0);
        chk("rst_busy0", busy0, 0);
        chk("rst_cs1", cs1, 0);
        chk("rst_rdy2", i2.ready, 0);
        sel2 = 2'd3;
        rst_n = 1'b1;

        // Select mode: sel moves to 1 mid-packet, ch1 must wait for A3.
        @(negedge clk); #2;
        srcq[2].push_back({1'b0, 8'hA1});
        srcq[2].push_back({1'b0, 8'hA2});
        srcq[2].push_back({1'b1, 8'hA3});
        srcq[1].push_back({1'b1, 8'hB1});
        exp_q.push_back({1'b0, 8'hA1});
        exp_q.push_back({1'b0, 8'hA2});
        exp_q.push_back({1'b1, 8'hA3});
        exp_q.push_back({1'b1, 8'hB1});
        sel = 2'd2;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #2;
            chk("t1_rdy", act_ready, t1_rdy[k]);
            chk("t1_busy", act_busy, t1_busy[k]);
            chk("t1_ov", act_valid, t1_ov[k]);
            if (k == 1) sel = 2'd1;
        end
        @(negedge clk); #2;
        chk("t1_drain", exp_q.size(), 0);
        repeat (2) @(negedge clk);

        // Round robin, all channels valid with single-beat packets.
        #2;
        use_rr = 1'b1;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++) begin
                srcq[c].push_back({1'b1, 8'(8'h10 + c)});
                exp_q.push_back({1'b1, 8'(8'h10 + c)});
            end
        wait_drain("t2", 12);
        repeat (2) @(negedge clk);

        // Backpressure on a 4-beat packet from ch0.
        #2;
        use_rr = 1'b0;
        sel = 2'd0;
        bp_chk = 1'b1;
        bp_en = 1'b1;
        for (int b = 0; b < 4; b++) begin
            srcq[0].push_back({(b == 3), 8'(8'hC0 + b)});
            exp_q.push_back({(b == 3), 8'(8'hC0 + b)});
        end
        wait_drain("t3", 0);
        bp_en = 1'b0;
        bp_chk = 1'b0;
        repeat (3) @(negedge clk);

        // Out-of-range select on the 3-channel instance, then a legal one.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #2;
            chk("t4_rdy", i2.ready, 0);
            chk("t4_ov", o2.valid, 0);
        end
        sel2 = 2'd2;
        #1;
        chk("t4_rdy_ok", i2.ready, 3'b100);
        @(negedge clk); #2;
        chk("t4_ov_ok", o2.valid, 1);
        chk("t4_data_ok", o2.data, 8'h22);
        chk("t4_cs_ok", cs2, 2);

        // Reset after the second beat of a 4-beat packet on ch2.
        @(negedge clk); #2;
        sel = 2'd2;
        for (int b = 0; b < 4; b++) srcq[2].push_back({(b == 3), 8'(8'hD0 + b)});
        exp_q.push_back({1'b0, 8'hD0});
        exp_q.push_back({1'b0, 8'hD1});
        repeat (3) @(negedge clk);
        #2;
        chk("t5_pre_busy", busy0, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_ov", o0.valid, 0);
        chk("t5_busy", busy0, 0);
        chk("t5_cs", cs0, 0);
        chk("t5_rdy", i0.ready, 0);
        chk("t5_sb", exp_q.size(), 0);
        for (int c = 0; c < 4; c++) srcq[c] = {};
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        use_rr = 1'b1;
        #2;
        srcq[3].push_back({1'b1, 8'h33});
        srcq[0].push_back({1'b1, 8'h30});
        exp_q.push_back({1'b1, 8'h30});
        exp_q.push_back({1'b1, 8'h33});
        wait_drain("t5", 2);
        repeat (2) @(negedge clk);

        // Round robin, only ch3 valid, 2-beat packets back to back.
        #2;
        busy_chk = 1'b1;
        for (int p = 0; p < 3; p++) begin
            srcq[3].push_back({1'b0, 8'(8'h60 + 2*p)});
            srcq[3].push_back({1'b1, 8'(8'h61 + 2*p)});
            exp_q.push_back({1'b0, 8'(8'h60 + 2*p)});
            exp_q.push_back({1'b1, 8'(8'h61 + 2*p)});
        end
        wait_drain("t6", 6);
        busy_chk = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
